alu_seq: RTL and testbench

//  Parametrised, clocked successor of the 8-bit ADD/AND ALU. It registers the

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_mul_iter.sv | 58 +++++
 rtl/alu_seq.sv | 145 ++++++++++++++
 tb/tb_alu_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the sequential ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
   localparam logic [OP_W-1:0] OP_AND   = 3'b001;
   localparam logic [OP_W-1:0] OP_SUB   = 3'b010;
   localparam logic [OP_W-1:0] OP_OR    = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR   = 3'b100;
   localparam logic [OP_W-1:0] OP_SLT   = 3'b101;
   localparam logic [OP_W-1:0] OP_MUL   = 3'b110;
   localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier datapath: one partial product per cycle after start.
// Latency: done pulses in the WIDTH-th cycle after start, product valid with it.
// Backpressure: none; the caller must capture product on the done cycle.
module alu_mul_iter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   logic               run;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [CNT_W-1:0]   cnt;

   // Next accumulator value; product is exposed early so the final add lands in the caller's register.
   always_comb begin
      acc_nxt = acc;
      if (mplier[0]) begin
         acc_nxt = acc + ({{WIDTH{1'b0}}, mcand} << cnt);
      end
      done    = run && (cnt == CNT_W'(WIDTH - 1));
      product = acc_nxt;
   end

   // Operand latch on start, then one iteration per cycle until the last bit is consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         run    <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (start) begin
         run    <= 1'b1;
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (run) begin
         acc    <= acc_nxt;
         mplier <= mplier >> 1;
         cnt    <= cnt + CNT_W'(1);
         if (done) begin
            run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with valid/ready handshake, eight ops including iterative multiply.
// Latency: accept to out_valid is 1 cycle (single-cycle ops) or WIDTH+1 cycles (MUL).
// Backpressure: result held in DONE until out_ready; in_ready only high in IDLE.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             zero,
   output logic             carry,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state_q;
   state_t             state_d;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] product;
   logic               load_alu;
   logic               load_mul;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   alu_c;
   logic               alu_carry;
   logic               alu_ovf;

   alu_mul_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (product)
   );

   // Single-cycle ops straight from the live inputs; only captured on accept.
   always_comb begin
      sum       = {1'b0, a} + {1'b0, b};
      diff      = {1'b0, a} - {1'b0, b};
      alu_c     = b;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_c     = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_c     = diff[WIDTH-1:0];
            alu_carry = diff[WIDTH];
            alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:   alu_c = a & b;
         OP_OR:    alu_c = a | b;
         OP_XOR:   alu_c = a ^ b;
         OP_SLT:   alu_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_PASSB: alu_c = b;
         default:  alu_c = b;
      endcase
   end

   // Handshake FSM: next state plus the strobes that load the result registers.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      mul_start = 1'b0;
      load_alu  = 1'b0;
      load_mul  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (op == OP_MUL) begin
                  mul_start = 1'b1;
                  state_d   = BUSY;
               end else begin
                  load_alu = 1'b1;
                  state_d  = DONE;
               end
            end
         end
         BUSY: begin
            if (mul_done) begin
               load_mul = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Result/flag registers; zero is derived from whichever value is being stored.
   always_ff @(posedge clk) begin
      if (rst) begin
         c     <= '0;
         zero  <= 1'b0;
         carry <= 1'b0;
         ovf   <= 1'b0;
      end else if (load_alu) begin
         c     <= alu_c;
         zero  <= (alu_c == '0);
         carry <= alu_carry;
         ovf   <= alu_ovf;
      end else if (load_mul) begin
         c     <= product[WIDTH-1:0];
         zero  <= (product[WIDTH-1:0] == '0);
         carry <= |product[2*WIDTH-1:WIDTH];
         ovf   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8 using a result scoreboard.
// Latency: checks 1-cycle and 9-cycle accept-to-valid timing.
// Backpressure: holds out_ready low and checks the result stays put.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] c;
   logic         zero;
   logic         carry;
   logic         ovf;

   typedef struct {
      logic [7:0] c;
      logic       zero;
      logic       carry;
      logic       ovf;
      int         lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .zero      (zero),
      .carry     (carry),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Reference behaviour written with plain integer arithmetic.
   function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      exp_t e;
      int ux = x;
      int uy = y;
      int sx = int'($signed(x));
      int sy = int'($signed(y));
      int r  = 0;
      e.carry = 1'b0;
      e.ovf   = 1'b0;
      e.lat   = 1;
      case (o)
         3'b000: begin
            r = ux + uy;
            e.carry = (r > 255);
            e.ovf   = ((sx + sy) > 127) || ((sx + sy) < -128);
         end
         3'b001: r = ux & uy;
         3'b010: begin
            r = ux - uy;
            e.carry = (ux < uy);
            e.ovf   = ((sx - sy) > 127) || ((sx - sy) < -128);
         end
         3'b011: r = ux | uy;
         3'b100: r = ux ^ uy;
         3'b101: r = (sx < sy) ? 1 : 0;
         3'b110: begin
            r = ux * uy;
            e.carry = (r > 255);
            e.lat   = 9;
         end
         default: r = uy;
      endcase
      e.c    = r[7:0];
      e.zero = (e.c == 8'd0);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
   endtask

   task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input string tag);
      wait_ready(tag);
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      sb_q.push_back(model(o, x, y));
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 3'($urandom);
   endtask

   task automatic collect(input string tag);
      int   n = 0;
      exp_t e;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_vld"}, 32'(out_valid), 32'd1);
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_c"},     32'(c),     32'(e.c));
         check({tag, "_zero"},  32'(zero),  32'(e.zero));
         check({tag, "_carry"}, 32'(carry), 32'(e.carry));
         check({tag, "_ovf"},   32'(ovf),   32'(e.ovf));
         check({tag, "_lat"},   32'(cyc - acc_cyc + 1), 32'(e.lat));
      end
      if (out_ready) begin
         @(posedge clk); #1;
         check({tag, "_drop"}, {30'd0, out_valid, in_ready}, 32'b01);
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input string tag);
      issue(o, x, y, tag);
      collect(tag);
   endtask

   initial begin
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a  = '0;
      b  = '0;
      op = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_c",    32'(c), 32'd0);
      check("rst_flag", {29'd0, zero, carry, ovf}, 32'd0);
      check("rst_vld",  32'(out_valid), 32'd0);
      rst = 1'b0;
      check("rst_rdy",  32'(in_ready), 32'd1);

      run_op(3'b000, 8'd8,   8'd6,   "add_8_6");
      run_op(3'b001, 8'd8,   8'd6,   "and_8_6");
      run_op(3'b000, 8'd200, 8'd100, "add_carry");
      run_op(3'b000, 8'd127, 8'd1,   "add_ovf");
      run_op(3'b010, 8'd3,   8'd5,   "sub_borrow");
      run_op(3'b010, 8'h80,  8'd1,   "sub_ovf");
      run_op(3'b101, 8'hFE,  8'd1,   "slt_neg");
      run_op(3'b101, 8'd1,   8'hFE,  "slt_pos");
      run_op(3'b100, 8'hA5,  8'hA5,  "xor_zero");
      run_op(3'b111, 8'd9,   8'h3C,  "passb");
      run_op(3'b110, 8'd12,  8'd11,  "mul_12_11");
      run_op(3'b110, 8'd20,  8'd20,  "mul_20_20");
      run_op(3'b110, 8'd0,   8'd255, "mul_0_255");
      run_op(3'b110, 8'd255, 8'd255, "mul_max");

      for (int i = 0; i < 16; i++) begin
         run_op(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), $sformatf("rand%0d", i));
      end

      // Backpressure: result must sit still and new requests must be refused.
      out_ready = 1'b0;
      issue(3'b011, 8'hF0, 8'h0F, "bp_or");
      collect("bp_or");
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         op = 3'b000;
         a  = 8'd1;
         b  = 8'd1;
         @(posedge clk); #1;
         check($sformatf("bp_hold%0d", i), {22'd0, c, out_valid, in_ready}, {22'd0, 8'hFF, 1'b1, 1'b0});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
      out_ready = 1'b1;

      // New request during BUSY must not be taken.
      issue(3'b110, 8'd12, 8'd11, "busy_ign");
      in_valid = 1'b1;
      op = 3'b000;
      a  = 8'd1;
      b  = 8'd1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      collect("busy_ign");
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      check("busy_no_extra", 32'(seen), 32'd0);

      // Reset in BUSY cycle 4 aborts the multiply.
      issue(3'b110, 8'd20, 8'd20, "abort");
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb_q.delete();
      check("abort_c",    32'(c), 32'd0);
      check("abort_flag", {29'd0, zero, carry, ovf}, 32'd0);
      check("abort_vld",  32'(out_valid), 32'd0);
      check("abort_rdy",  32'(in_ready), 32'd1);
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      check("abort_never", 32'(seen), 32'd0);
      run_op(3'b000, 8'd1, 8'd1, "post_abort");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
